// File: rtl/xor_sched_pkg.sv
// Shared types and sizing helpers for the XOR parity scheduler.
package xor_sched_pkg;

  // Engine sequencing: accept an operand, shift it through the XOR, publish.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // Bit counter width: one extra bit so the count never wraps inside an operation.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNTW = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/xor_parity_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after 'last', wrapping.
// Purely combinational; the owner registers the pointer on a grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic           found;
  logic [IDW-1:0] cand;

  // Scan last+1 .. last+NREQ (mod NREQ); the final step revisits 'last' itself,
  // so the previous winner only wins again when nobody else is asking.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = last + IDW'(off);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (en && found) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/xor_parity_sched.sv
// Round-robin front end sharing one bit-serial XOR reduction engine between
// NREQ requesters. A granted operand is shifted LSB first through a single
// XOR/accumulator; the parity comes back tagged with the requester index.
//
// Handshake: a requester holds req (and its data) high until it sees its gnt
// bit. gnt is a one-cycle pulse in which the operand is sampled; the requester
// drops req on the following cycle. done is a one-cycle pulse that marks
// parity/result_id valid; both hold their value until the next done.
module xor_parity_sched
  import xor_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic                  parity,
  output logic [IDW-1:0]        result_id,
  output logic [1:0]            dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] sreg;
  logic            acc;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  id;
  logic [IDW-1:0]  last;

  logic            arb_en;
  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;

  // Grants are only offered from IDLE, and never while reset is asserted.
  assign arb_en = (state == IDLE) && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req  (req),
    .last (last),
    .en   (arb_en),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign gnt       = arb_gnt;
  assign busy      = (state == SHIFT) || (state == DONE);
  assign dbg_state = state;

  // Engine sequencer: latch winner's operand, shift WIDTH bits, publish result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      acc       <= 1'b0;
      cnt       <= '0;
      id        <= '0;
      last      <= IDW'(NREQ - 1);
      done      <= 1'b0;
      parity    <= 1'b0;
      result_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (|arb_gnt) begin
            sreg  <= data[arb_idx*WIDTH +: WIDTH];
            acc   <= 1'b0;
            cnt   <= '0;
            id    <= arb_idx;
            last  <= arb_idx;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc  <= acc ^ sreg[0];
          sreg <= sreg >> 1;
          cnt  <= cnt + 1'b1;
          // Last bit: publish the folded value directly so parity is valid with done.
          if (cnt == LAST_CNT) begin
            state     <= DONE;
            done      <= 1'b1;
            parity    <= acc ^ sreg[0];
            result_id <= id;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/xor_parity_sched.md
Name: xor_parity_sched

Overview:
- Round-robin scheduler that shares one bit-serial XOR reduction engine between NREQ requesters.
- Each accepted operand is reduced one bit per clock: acc <= acc ^ bit.
- Final parity is returned tagged with the requester index.
- Sits in front of the team's XOR gate datapath. The shared engine is a single xor gate plus accumulator flop.

Parameters:
- NREQ, 4, number of requesters (power of 2, at least 2).
- WIDTH, 8, operand width in bits (at least 2).
- IDW, $clog2(NREQ), width of the requester index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  NREQ  per-requester request level. Held high until granted.
- data  input  NREQ*WIDTH  operands. Requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot, one-cycle pulse; operand sampled in that cycle.
- busy  output  1  high while the engine is in SHIFT or DONE.
- done  output  1  one-cycle pulse; result valid.
- parity  output  1  XOR of all WIDTH bits of the granted operand. Held until the next done.
- result_id  output  IDW  index of the requester whose result is on parity. Held with parity.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; gnt, busy, done, parity, result_id, acc, cnt all 0.
  - Round-robin pointer last=NREQ-1, so requester 0 has highest priority first.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - If req != 0, winner = first set bit searching from last+1, wrapping modulo NREQ.
  - In the same clock: gnt[winner]=1, sreg<=operand of winner, acc<=0, cnt<=0, id<=winner, last<=winner, go to SHIFT.
  - If req == 0, stay in IDLE with gnt=0.
- SHIFT (busy=1):
  - Each clock: acc<=acc^sreg[0], sreg<=sreg>>1, cnt<=cnt+1.
  - After WIDTH shift cycles (cnt==WIDTH-1 at the edge) go to DONE.
- DONE (busy=1, registered outputs):
  - done=1 for exactly one cycle; parity<=final acc, result_id<=id.
  - Next state is IDLE. No grant is issued in DONE.
- Latency: gnt in cycle t, done high in cycle t+WIDTH+1. Throughput is one operand per WIDTH+2 cycles.
- Requester contract:
  - Hold req and data stable until gnt is seen, then drop req the following cycle.
  - A req that falls before its grant is simply not served.
  - Data changes after gnt have no effect (operand already latched).
- Simultaneous requests: exactly one grant per IDLE visit. Fairness is strict round-robin, so no requester waits more than NREQ-1 services.
- A requester still holding req after its own done is eligible again, but only after all others pending.
- Reset mid-SHIFT or mid-DONE: operation aborted, no done pulse, pointer back to NREQ-1.
- cnt is $clog2(WIDTH)+1 bits wide and never wraps inside an operation.

Decomposition:
- Package xor_sched_pkg holds:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - localparam CNTW = $clog2(WIDTH)+1.
- One natural sub-module: rr_arbiter (parameter NREQ).
  - Inputs: req, last, en. Outputs: one-hot gnt, encoded idx.
  - Purely combinational with a registered pointer update in the parent.
- The XOR engine stays inline (sreg, acc, cnt).

Test Plan:
- Reset, then req=4'b0001 with data0=8'hA5 -> gnt=4'b0001 at t; done at t+9 with parity=0, result_id=0.
- req=4'b0010 with data1=8'h07 -> gnt=4'b0010; done with parity=1, result_id=1; busy high for exactly 9 cycles.
- Reset, then req=4'b1111 held (each dropped after its gnt) -> grants in order 0,1,2,3. Four done pulses spaced 10 cycles apart.
- req0 and req2 both held continuously -> grant order 0,2,0,2; no requester granted twice in a row while the other is pending.
- data3=8'hFF then data3=8'h00 -> parity 0 both times. data3=8'h80 -> parity 1 (MSB processed last).
- rst pulsed in cycle t+4 of a SHIFT -> all outputs 0 immediately, no done. Next req=4'b1000 -> gnt=4'b1000 and correct result.
